// File: rtl/pipeline_control.sv
// Pipeline enable/flush sequencing for the 5-stage MIPS core: hazard response,
// HALT drain, debug freeze/single-step and a pipeline-advance counter.
//
// state   | meaning
// RUN     | normal issue; hazard requests map to enables/flushes
// DRAIN   | fetch stopped, bubbles inserted while older instructions retire
// HALTED  | pipeline parked until i_restart
module pipeline_control #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic             i_halt,
  input  logic             i_dbg_en,
  input  logic             i_dbg_step,
  input  logic             i_restart,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_pipe_en,
  output logic             o_halted,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_adv_count
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  localparam logic [1:0]    ST_RUN     = 2'b00;
  localparam logic [1:0]    ST_DRAIN   = 2'b01;
  localparam logic [1:0]    ST_HALTED  = 2'b10;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] adv_cnt_q, adv_cnt_d;

  logic adv;
  logic pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en;

  assign adv = !i_dbg_en || i_dbg_step;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_RUN;
      drain_q   <= '0;
      adv_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      adv_cnt_q <= adv_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    adv_cnt_d = adv_cnt_q + CNT_W'(pipe_en);
    case (state_q)
      ST_RUN: begin
        if (adv && !i_flush && i_halt) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (adv) begin
          if (drain_q != '0) drain_d = drain_q - DW'(1);
          else               state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (i_restart) begin
          state_d   = ST_RUN;
          adv_cnt_d = '0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Everything is gated by i_rst_n so the pipeline is frozen the instant reset asserts.
  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_en     = 1'b0;
    if (i_rst_n && adv) begin
      case (state_q)
        ST_RUN: begin
          pipe_en = 1'b1;
          if (i_flush)
            {pc_en, if_id_en, if_id_flush, id_ex_flush} = 4'b1111;
          else if (i_halt)
            {pc_en, if_id_en, if_id_flush, id_ex_flush} = 4'b0011;
          else if (i_stall)
            {pc_en, if_id_en, if_id_flush, id_ex_flush} = 4'b0001;
          else
            {pc_en, if_id_en, if_id_flush, id_ex_flush} = 4'b1100;
        end
        ST_DRAIN: begin
          pipe_en = 1'b1;
          {pc_en, if_id_en, if_id_flush, id_ex_flush} = 4'b0011;
        end
        default: ;
      endcase
    end
  end

  assign o_pc_en       = pc_en;
  assign o_if_id_en    = if_id_en;
  assign o_if_id_flush = if_id_flush;
  assign o_id_ex_flush = id_ex_flush;
  assign o_pipe_en     = pipe_en;
  assign o_halted      = (state_q == ST_HALTED) && i_rst_n;
  assign o_state       = state_q;
  assign o_adv_count   = adv_cnt_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Bench for pipeline_control: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pipeline_control;

  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W        = 32;

  logic i_clk, i_rst_n;
  logic i_stall, i_flush, i_halt, i_dbg_en, i_dbg_step, i_restart;
  logic o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush, o_pipe_en, o_halted;
  logic [1:0]       o_state;
  logic [CNT_W-1:0] o_adv_count;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_control #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_stall(i_stall), .i_flush(i_flush), .i_halt(i_halt),
    .i_dbg_en(i_dbg_en), .i_dbg_step(i_dbg_step), .i_restart(i_restart),
    .o_pc_en(o_pc_en), .o_if_id_en(o_if_id_en), .o_if_id_flush(o_if_id_flush),
    .o_id_ex_flush(o_id_ex_flush), .o_pipe_en(o_pipe_en), .o_halted(o_halted),
    .o_state(o_state), .o_adv_count(o_adv_count)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 RUN, 1 DRAIN, 2 HALTED; m_left = advancing drain cycles remaining.
  int               m_mode = 0;
  int               m_left = 0;
  logic [CNT_W-1:0] m_cnt  = '0;

  // {pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en}
  function automatic logic [4:0] exp_ctl();
    bit adv;
    adv = !i_dbg_en || i_dbg_step;
    if (!i_rst_n || !adv || m_mode == 2) return 5'b00000;
    if (m_mode == 1) return 5'b00111;
    if (i_flush)     return 5'b11111;
    if (i_halt)      return 5'b00111;
    if (i_stall)     return 5'b00011;
    return 5'b11001;
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    logic [4:0] e;
    bit adv;
    if (!i_rst_n) begin
      m_mode = 0;
      m_left = 0;
      m_cnt  = '0;
    end else begin
      e   = exp_ctl();
      adv = !i_dbg_en || i_dbg_step;
      if (e[0]) m_cnt = m_cnt + 1;
      if (m_mode == 0) begin
        if (adv && !i_flush && i_halt) begin
          m_mode = 1;
          m_left = DRAIN_CYCLES;
        end
      end else if (m_mode == 1) begin
        if (adv) begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = 2;
        end
      end else if (i_restart) begin
        m_mode = 0;
        m_cnt  = '0;
      end
    end
  end

  always @(negedge i_clk) begin
    check("ctl_vec", {o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush, o_pipe_en}, exp_ctl());
    check("halted", o_halted, (m_mode == 2) && i_rst_n);
    check("state", o_state, m_mode[1:0]);
    check("adv_count", o_adv_count, m_cnt);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clr();
    {i_stall, i_flush, i_halt, i_dbg_en, i_dbg_step, i_restart} = 6'b0;
  endtask

  int cnt_before;

  initial begin
    i_rst_n = 1'b0;
    clr();
    repeat (2) tick();
    check("rst_state", o_state, 2'b00);
    check("rst_count", o_adv_count, 0);
    check("rst_ctl", {o_pc_en, o_if_id_en, o_pipe_en, o_halted}, 4'b0000);
    i_rst_n = 1'b1;

    // idle
    repeat (10) tick();
    check("idle_count", o_adv_count, 10);
    check("idle_state", o_state, 2'b00);

    // load-use stall
    i_stall = 1'b1;
    repeat (2) begin
      #2;
      check("stall_ctl", {o_pc_en, o_if_id_en, o_id_ex_flush, o_pipe_en}, 4'b0011);
      tick();
    end
    clr();
    check("stall_count", o_adv_count, 12);

    // flush beats stall, flush beats halt
    i_flush = 1'b1; i_stall = 1'b1;
    #2;
    check("flush_stall", {o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush}, 4'b1111);
    tick();
    i_stall = 1'b0; i_halt = 1'b1;
    tick();
    clr();
    check("flush_halt_state", o_state, 2'b00);

    // halt drain, cycle T
    cnt_before = int'(o_adv_count);
    i_halt = 1'b1;
    #2;
    check("halt_pc_en", o_pc_en, 1'b0);
    tick();
    clr();
    for (int k = 1; k <= 3; k++) begin
      #2;
      check("drain_state", o_state, 2'b01);
      tick();
    end
    check("halted_state", o_state, 2'b10);
    check("halted_flag", o_halted, 1'b1);
    check("halt_adv_delta", o_adv_count, cnt_before + 4);
    tick();
    tick();
    i_restart = 1'b1;
    tick();
    clr();
    check("restart_state", o_state, 2'b00);
    check("restart_count", o_adv_count, 0);

    // debug-stepped drain
    i_halt = 1'b1;
    tick();
    clr();
    i_dbg_en = 1'b1;
    for (int s = 0; s < 3; s++) begin
      repeat (2) begin
        #2;
        check("dbg_frozen", {o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush, o_pipe_en}, 5'b0);
        tick();
      end
      check("dbg_pre_step_state", o_state, 2'b01);
      i_dbg_step = 1'b1;
      tick();
      i_dbg_step = 1'b0;
    end
    check("dbg_halted", o_state, 2'b10);
    i_restart = 1'b1;
    tick();
    clr();

    // reset mid-drain
    i_halt = 1'b1;
    tick();
    clr();
    tick();
    #2;
    i_rst_n = 1'b0;
    #1;
    check("amid_ctl", {o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush, o_pipe_en, o_halted}, 6'b0);
    check("amid_state", o_state, 2'b00);
    check("amid_count", o_adv_count, 0);
    tick();
    i_rst_n = 1'b1;
    tick();
    check("post_rst_run", {o_state, o_pc_en, o_halted}, 4'b0010);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      i_stall    = ($urandom_range(99) < 20);
      i_flush    = ($urandom_range(99) < 10);
      i_halt     = ($urandom_range(99) < 5);
      i_dbg_step = ($urandom_range(99) < 30);
      i_restart  = ($urandom_range(99) < 15);
      if ($urandom_range(99) < 5) i_dbg_en = ~i_dbg_en;
      i_rst_n    = ($urandom_range(199) != 0);
      tick();
    end
    clr();
    i_rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
